// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: data word, register index and the
// EX/MEM memory-access FSM state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // A simultaneous read and write request is served as a read, so either
  // flag alone is enough to make the instruction a memory operation.
  function automatic logic is_memop(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/ex_mem_ctrl.sv
// EX/MEM memory-access controller. Tracks whether the stage is idle,
// waiting on the memory bus, or has just completed an access.
// mem_stall is a pure decode of the registered state; mem_resp only
// influences the next state, never the stall output directly.
module ex_mem_ctrl
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       capture_memop,
  input  logic       mem_resp,
  output mem_state_e state,
  output logic       mem_stall
);

  mem_state_e state_r;
  mem_state_e next_s;

  // Next-state selection: captures only happen outside ACCESS.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_memop) next_s = ST_ACCESS;
        else               next_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (mem_resp) next_s = ST_DONE;
        else          next_s = ST_ACCESS;
      end
      ST_DONE: begin
        if (capture_memop) next_s = ST_ACCESS;
        else               next_s = ST_IDLE;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State register, cleared asynchronously so the bus drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= next_s;
  end

  assign state     = state_r;
  assign mem_stall = (state_r == ST_ACCESS);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with an attached memory-access controller.
// Optional build macro EX_MEM_STALL_CNT_EN adds a saturating 32-bit
// stall_count output counting cycles spent stalled on memory.
module ex_mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  lc3b_word    ex_alu_out,
  input  lc3b_word    ex_store_data,
  input  lc3b_reg     ex_dr,
  input  logic        ex_load_regfile,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_byte_en,
  input  logic        flush,
  input  logic        mem_resp,
  input  lc3b_word    mem_rdata,
  output logic        ex_mem_valid,
  output lc3b_reg     ex_mem_dr_out,
  output logic        ex_mem_load_regfile,
  output lc3b_word    ex_mem_result,
  output lc3b_word    mem_address,
  output lc3b_word    mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0] stall_count,
`endif
  output logic        mem_stall
);

  mem_state_e state_s;
  logic       stall_s;
  logic       capture_s;
  logic       capture_memop_s;
  logic       in_access_s;

  logic       valid_r;
  logic       ld_r;
  logic       rd_r;
  logic       wr_r;
  logic       squashed_r;
  lc3b_reg    dr_r;
  lc3b_word   alu_r;
  lc3b_word   store_r;
  lc3b_word   result_r;
  logic [1:0] be_r;

  assign capture_s       = ~stall_s;
  assign capture_memop_s = capture_s & ~flush & ex_valid &
                           is_memop(ex_mem_read, ex_mem_write);
  assign in_access_s     = (state_s == ST_ACCESS);

  ex_mem_ctrl u_ctrl (
    .clk           (clk),
    .reset_n       (reset_n),
    .capture_memop (capture_memop_s),
    .mem_resp      (mem_resp),
    .state         (state_s),
    .mem_stall     (stall_s)
  );

  // Pipeline register: capture when not stalled (flush loads a bubble),
  // otherwise hold, latching read data and any flush seen mid-access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r    <= 1'b0;
      ld_r       <= 1'b0;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      squashed_r <= 1'b0;
      dr_r       <= 3'd0;
      alu_r      <= 16'h0000;
      store_r    <= 16'h0000;
      result_r   <= 16'h0000;
      be_r       <= 2'b00;
    end else if (capture_s) begin
      valid_r    <= ex_valid & ~flush;
      ld_r       <= ex_load_regfile & ~flush;
      rd_r       <= ex_mem_read & ~flush;
      wr_r       <= ex_mem_write & ~ex_mem_read & ~flush;
      squashed_r <= 1'b0;
      dr_r       <= ex_dr;
      alu_r      <= ex_alu_out;
      store_r    <= ex_store_data;
      result_r   <= ex_alu_out;
      be_r       <= ex_byte_en;
    end else begin
      if (flush) squashed_r <= 1'b1;
      if (mem_resp && rd_r) result_r <= mem_rdata;
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_count_r;

  // Saturating count of clock edges spent stalled on memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  stall_count_r <= 32'd0;
    else if (stall_s && stall_count_r != 32'hFFFF_FFFF) stall_count_r <= stall_count_r + 32'd1;
    else                                           stall_count_r <= stall_count_r;
  end

  assign stall_count = stall_count_r;
`endif

  assign ex_mem_valid        = valid_r;
  assign ex_mem_dr_out       = dr_r;
  assign ex_mem_load_regfile = valid_r & ld_r & ~squashed_r;
  assign ex_mem_result       = result_r;
  assign mem_read            = in_access_s & rd_r;
  assign mem_write           = in_access_s & wr_r;
  assign mem_address         = in_access_s ? alu_r   : 16'h0000;
  assign mem_wdata           = in_access_s ? store_r : 16'h0000;
  assign mem_byte_enable     = in_access_s ? be_r    : 2'b00;
  assign mem_stall           = stall_s;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a transaction-level
// reference model of the stage.
module tb_ex_mem_stage;
  import lc3b_types::*;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic [15:0] ex_alu_out;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_dr;
  logic        ex_load_regfile;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_byte_en;
  logic        flush;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        ex_mem_valid;
  logic [2:0]  ex_mem_dr_out;
  logic        ex_mem_load_regfile;
  logic [15:0] ex_mem_result;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_stall;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int vectors;
  int miscompares;

  // Reference model: one outstanding instruction plus whether it still
  // owns the memory bus.
  bit          m_valid, m_ld, m_rd, m_wr, m_busy, m_squash;
  logic [2:0]  m_dr;
  logic [15:0] m_result, m_addr, m_wdata;
  logic [1:0]  m_be;
  longint unsigned m_stalls;

  ex_mem_stage dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .ex_valid            (ex_valid),
    .ex_alu_out          (ex_alu_out),
    .ex_store_data       (ex_store_data),
    .ex_dr               (ex_dr),
    .ex_load_regfile     (ex_load_regfile),
    .ex_mem_read         (ex_mem_read),
    .ex_mem_write        (ex_mem_write),
    .ex_byte_en          (ex_byte_en),
    .flush               (flush),
    .mem_resp            (mem_resp),
    .mem_rdata           (mem_rdata),
    .ex_mem_valid        (ex_mem_valid),
    .ex_mem_dr_out       (ex_mem_dr_out),
    .ex_mem_load_regfile (ex_mem_load_regfile),
    .ex_mem_result       (ex_mem_result),
    .mem_address         (mem_address),
    .mem_wdata           (mem_wdata),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_byte_enable     (mem_byte_enable),
`ifdef EX_MEM_STALL_CNT_EN
    .stall_count         (stall_count),
`endif
    .mem_stall           (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ld = 0; m_rd = 0; m_wr = 0; m_busy = 0; m_squash = 0;
    m_dr = 3'd0; m_result = 16'h0000; m_addr = 16'h0000;
    m_wdata = 16'h0000; m_be = 2'b00; m_stalls = 0;
  endtask

  // Advance the model by one clock edge using the inputs as driven.
  task automatic model_edge();
    if (m_busy) begin
      if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (flush) m_squash = 1;
      if (mem_resp) begin
        m_busy = 0;
        if (m_rd) m_result = mem_rdata;
      end
    end else begin
      if (flush) begin
        m_valid = 0; m_ld = 0; m_rd = 0; m_wr = 0;
      end else begin
        m_valid  = ex_valid;
        m_ld     = ex_load_regfile;
        m_rd     = ex_mem_read;
        m_wr     = ex_mem_write && !ex_mem_read;
        m_dr     = ex_dr;
        m_result = ex_alu_out;
        m_addr   = ex_alu_out;
        m_wdata  = ex_store_data;
        m_be     = ex_byte_en;
      end
      m_squash = 0;
      m_busy   = !flush && ex_valid && (ex_mem_read || ex_mem_write);
    end
  endtask

  task automatic check_all();
    chk("mem_stall", mem_stall, m_busy);
    chk("mem_read", mem_read, m_busy && m_rd);
    chk("mem_write", mem_write, m_busy && m_wr);
    chk("mem_address", mem_address, m_busy ? m_addr : 16'h0000);
    chk("mem_wdata", mem_wdata, m_busy ? m_wdata : 16'h0000);
    chk("mem_byte_enable", mem_byte_enable, m_busy ? m_be : 2'b00);
    chk("ex_mem_valid", ex_mem_valid, m_valid);
    chk("ex_mem_load_regfile", ex_mem_load_regfile, m_valid && m_ld && !m_squash);
    if (m_valid) begin
      chk("ex_mem_dr_out", ex_mem_dr_out, m_dr);
      chk("ex_mem_result", ex_mem_result, m_result);
    end
`ifdef EX_MEM_STALL_CNT_EN
    chk("stall_count", stall_count, m_stalls[31:0]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_op(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [2:0] dr, input logic ld, input logic rd,
                        input logic wr, input logic [1:0] be);
    ex_valid = v; ex_alu_out = alu; ex_store_data = sd; ex_dr = dr;
    ex_load_regfile = ld; ex_mem_read = rd; ex_mem_write = wr; ex_byte_en = be;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, ex_mem_valid, 1'b0);
    chk({tag, "_ldreg"}, ex_mem_load_regfile, 1'b0);
    chk({tag, "_dr"}, ex_mem_dr_out, 3'd0);
    chk({tag, "_result"}, ex_mem_result, 16'h0000);
    chk({tag, "_addr"}, mem_address, 16'h0000);
    chk({tag, "_wdata"}, mem_wdata, 16'h0000);
    chk({tag, "_rd"}, mem_read, 1'b0);
    chk({tag, "_wr"}, mem_write, 1'b0);
    chk({tag, "_be"}, mem_byte_enable, 2'b00);
    chk({tag, "_stall"}, mem_stall, 1'b0);
`ifdef EX_MEM_STALL_CNT_EN
    chk({tag, "_cnt"}, stall_count, 32'd0);
`endif
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; flush = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0000;
    set_op(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // ALU op passes straight through in one cycle.
    set_op(1'b1, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 2'b00);
    step();
    chk("alu_dr", ex_mem_dr_out, 3'd3);
    chk("alu_ld", ex_mem_load_regfile, 1'b1);
    chk("alu_result", ex_mem_result, 16'h1234);
    chk("alu_stall", mem_stall, 1'b0);

    // Load at 0x0040, response three cycles late.
    set_op(1'b1, 16'h0040, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 2'b11);
    mem_rdata = 16'hBEEF;
    step();
    chk("ld_read_c1", mem_read, 1'b1);
    set_op(1'b1, 16'h7777, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_read_hold", mem_read, 1'b1);
      chk("ld_stall_hold", mem_stall, 1'b1);
      chk("ld_addr", mem_address, 16'h0040);
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("ld_done_result", ex_mem_result, 16'hBEEF);
    chk("ld_done_stall", mem_stall, 1'b0);
    chk("ld_done_read", mem_read, 1'b0);
    step();
    chk("ld_next_dr", ex_mem_dr_out, 3'd1);
    chk("ld_next_result", ex_mem_result, 16'h7777);

    // Store with byte lane 0 only.
    set_op(1'b1, 16'h0100, 16'hA5A5, 3'd4, 1'b0, 1'b0, 1'b1, 2'b01);
    step();
    set_op(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      chk("st_write", mem_write, 1'b1);
      chk("st_wdata", mem_wdata, 16'hA5A5);
      chk("st_be", mem_byte_enable, 2'b01);
      chk("st_ld", ex_mem_load_regfile, 1'b0);
      step();
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("st_done_ld", ex_mem_load_regfile, 1'b0);
    chk("st_done_result", ex_mem_result, 16'h0100);

    // Flush during the second ACCESS cycle of a load to R5.
    set_op(1'b1, 16'h0200, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 2'b11);
    mem_rdata = 16'h5A5A;
    step();
    set_op(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_read_kept", mem_read, 1'b1);
    chk("fl_ld_off", ex_mem_load_regfile, 1'b0);
    step();
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("fl_done_ld", ex_mem_load_regfile, 1'b0);
    chk("fl_done_read", mem_read, 1'b0);

    // Flush outside ACCESS loads a bubble even with a valid instruction.
    set_op(1'b1, 16'h0300, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 2'b11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_idle_valid", ex_mem_valid, 1'b0);
    chk("fl_idle_stall", mem_stall, 1'b0);

    // Stray response while idle is ignored.
    set_op(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("stray_stall", mem_stall, 1'b0);

    // Read and write together are served as a read.
    set_op(1'b1, 16'h0400, 16'h1111, 3'd7, 1'b1, 1'b1, 1'b1, 2'b10);
    step();
    chk("rw_read", mem_read, 1'b1);
    chk("rw_write", mem_write, 1'b0);
    mem_resp = 1'b1;
    mem_rdata = 16'h2222;
    step();
    mem_resp = 1'b0;

    // Asynchronous reset in the middle of an access.
    set_op(1'b1, 16'h0500, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 2'b11);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_zero("areset");
    @(negedge clk);
    reset_n = 1'b1;
    set_op(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("areset_resp_stall", mem_stall, 1'b0);
    chk("areset_resp_valid", ex_mem_valid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_op(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
             3'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), 2'($urandom));
      flush     = ($urandom_range(0, 9) == 0);
      mem_resp  = ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
